// File: rtl/imem_fetch_port.sv
// Byte-addressed big-endian instruction memory with a loader write port and a fetch handshake.
// Latency: a fetch accepted on edge N is presented on rsp_* right after edge N (1 cycle).
// Backpressure: the response holds while rsp_valid && !rsp_ready; loads stall fetches.
//
// Ports: clk, rst_n (async active-low)
//        load_en/load_addr/load_data : one-word loader write, dropped if out of range
//        req_valid/req_ready/req_addr: fetch request handshake
//        rsp_valid/rsp_ready/rsp_inst/rsp_err: registered fetch response
// Optional: define IMEM_MISALIGN_TRAP_EN to reject fetches and loads whose address is
//           not word aligned. Otherwise any byte alignment is legal.
module imem_fetch_port #(
  parameter int               AWIDTH      = 32,
  parameter int               IWIDTH      = 32,
  parameter int               DEPTH_BYTES = 1024,
  parameter logic [IWIDTH-1:0] NOP_INST   = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [AWIDTH-1:0] load_addr,
  input  logic [IWIDTH-1:0] load_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IWIDTH-1:0] rsp_inst,
  output logic              rsp_err
);

  localparam int IDX = $clog2(DEPTH_BYTES);
  localparam logic [AWIDTH:0] LAST_BYTE = (AWIDTH+1)'(DEPTH_BYTES - 1);

  logic [7:0] mem [DEPTH_BYTES];

  // Last byte touched by each access, one bit wider so an address wrap
  // past 2^AWIDTH shows up as out of range instead of aliasing low memory.
  logic [AWIDTH:0] load_end;
  logic [AWIDTH:0] fetch_end;
  logic            load_aligned;
  logic            fetch_aligned;
  logic            load_ok;
  logic            fetch_ok;
  logic            accept;
  logic [IDX-1:0]  li;
  logic [IDX-1:0]  fi;
  logic [IWIDTH-1:0] fetch_word;

  assign load_end  = {1'b0, load_addr} + (AWIDTH+1)'(3);
  assign fetch_end = {1'b0, req_addr}  + (AWIDTH+1)'(3);

`ifdef IMEM_MISALIGN_TRAP_EN
  assign load_aligned  = (load_addr[1:0] == 2'b00);
  assign fetch_aligned = (req_addr[1:0]  == 2'b00);
`else
  assign load_aligned  = 1'b1;
  assign fetch_aligned = 1'b1;
`endif

  assign load_ok  = load_en && (load_end <= LAST_BYTE) && load_aligned;
  assign fetch_ok = (fetch_end <= LAST_BYTE) && fetch_aligned;

  // Loads win the port; a fetch only proceeds when the response slot is free or draining.
  assign req_ready = !load_en && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  assign li = load_addr[IDX-1:0];
  assign fi = req_addr[IDX-1:0];

  // Index arithmetic never wraps here when the access is in range; out-of-range
  // results are discarded by fetch_ok/load_ok.
  always_comb begin
    fetch_word = {mem[fi], mem[fi + IDX'(1)], mem[fi + IDX'(2)], mem[fi + IDX'(3)]};
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[li]             <= load_data[31:24];
      mem[li + IDX'(1)]   <= load_data[23:16];
      mem[li + IDX'(2)]   <= load_data[15:8];
      mem[li + IDX'(3)]   <= load_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_inst  <= NOP_INST;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_inst  <= fetch_ok ? fetch_word : NOP_INST;
      rsp_err   <= !fetch_ok;
    end else if (rsp_ready) begin
      // Data and error flag keep their last value after the response drains.
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_port.sv
module tb_imem_fetch_port;

  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;

  int passed = 0;
  int total  = 0;

  imem_fetch_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mm [DEPTH];
  logic        m_valid;
  logic [31:0] m_inst;
  logic        m_err;
  bit          running = 1'b0;

  function automatic bit access_bad(input logic [31:0] a);
    longint unsigned last;
    bit bad;
    last = longint'(a) + 3;
    bad  = (last > longint'(DEPTH - 1));
`ifdef IMEM_MISALIGN_TRAP_EN
    if (a % 4 != 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a[9:0]);
    return {mm[b], mm[b+1], mm[b+2], mm[b+3]};
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_inst  = NOP;
      m_err   = 1'b0;
    end else begin
      if (req_valid && !load_en && (!m_valid || rsp_ready)) begin
        m_valid = 1'b1;
        if (access_bad(req_addr)) begin
          m_inst = NOP;
          m_err  = 1'b1;
        end else begin
          m_inst = model_word(req_addr);
          m_err  = 1'b0;
        end
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      if (load_en && !access_bad(load_addr)) begin
        for (int k = 0; k < 4; k++)
          mm[int'(load_addr[9:0]) + k] = load_data[31-8*k -: 8];
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (running) begin
      check("cmp_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
      check("cmp_req_ready", {31'b0, req_ready},
            {31'b0, !load_en && (!m_valid || rsp_ready)});
      check("cmp_rsp_inst", rsp_inst, m_inst);
      check("cmp_rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    cyc();
    load_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1; req_addr = a;
    cyc();
    req_valid = 1'b0;
  endtask

  logic [31:0] b2b_exp [3];
  logic [31:0] held;

  initial begin
    b2b_exp[0] = 32'h01020304;
    b2b_exp[1] = 32'h05060708;
    b2b_exp[2] = 32'h090A0B0C;

    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    #1;
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_inst", rsp_inst, 32'h00000013);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    running = 1'b1;

    load(32'h0, b2b_exp[0]);
    load(32'h4, b2b_exp[1]);
    load(32'h8, b2b_exp[2]);
    load(32'h10, 32'hDEADBEEF);
    load(32'h14, 32'h11223344);
    load(32'h3FC, 32'h0BADC0DE);

    fetch(32'h10);
    check("fetch10_valid", {31'b0, rsp_valid}, 32'd1);
    check("fetch10_inst", rsp_inst, 32'hDEADBEEF);
    check("fetch10_err", {31'b0, rsp_err}, 32'd0);

    fetch(32'h11);
`ifdef IMEM_MISALIGN_TRAP_EN
    check("fetch11_inst", rsp_inst, NOP);
    check("fetch11_err", {31'b0, rsp_err}, 32'd1);
    fetch(32'h12);
    check("fetch12_inst", rsp_inst, NOP);
    check("fetch12_err", {31'b0, rsp_err}, 32'd1);
`else
    check("fetch11_inst", rsp_inst, 32'hADBEEF11);
    check("fetch11_err", {31'b0, rsp_err}, 32'd0);
`endif

    // Back-to-back, no bubbles.
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      cyc();
      check("b2b_valid", {31'b0, rsp_valid}, 32'd1);
      check("b2b_inst", rsp_inst, b2b_exp[i]);
    end
    // Stall: request pending while consumer is not ready.
    rsp_ready = 1'b0; req_addr = 32'hC;
    held = b2b_exp[2];
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check("hold_inst", rsp_inst, held);
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    cyc();
    check("drain_valid", {31'b0, rsp_valid}, 32'd0);
    check("drain_inst_kept", rsp_inst, held);

    // Range boundaries.
    fetch(32'h3FC);
    check("fetch3fc_inst", rsp_inst, 32'h0BADC0DE);
    check("fetch3fc_err", {31'b0, rsp_err}, 32'd0);
    fetch(32'h3FD);
    check("fetch3fd_inst", rsp_inst, NOP);
    check("fetch3fd_err", {31'b0, rsp_err}, 32'd1);
    fetch(32'hFFFFFFFE);
    check("fetchwrap_inst", rsp_inst, NOP);
    check("fetchwrap_err", {31'b0, rsp_err}, 32'd1);
    load(32'h3FE, 32'hFFFFFFFF);
    fetch(32'h3FC);
    check("oor_load_dropped", rsp_inst, 32'h0BADC0DE);

    // Load and fetch in the same cycle: the load wins, the fetch follows.
    load_en = 1'b1; load_addr = 32'h20; load_data = 32'hCAFEF00D;
    req_valid = 1'b1; req_addr = 32'h20;
    #1;
    check("load_blocks_req", {31'b0, req_ready}, 32'd0);
    cyc();
    load_en = 1'b0;
    #1;
    check("req_after_load_ready", {31'b0, req_ready}, 32'd1);
    cyc();
    req_valid = 1'b0;
    check("fetch_new_word_valid", {31'b0, rsp_valid}, 32'd1);
    check("fetch_new_word", rsp_inst, 32'hCAFEF00D);

    // Asynchronous reset drops a pending response between edges.
    rsp_ready = 1'b0;
    fetch(32'h10);
    check("pre_reset_valid", {31'b0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {31'b0, rsp_valid}, 32'd0);
    check("async_reset_inst", rsp_inst, NOP);
    #3;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    cyc();
    cyc();

    running = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
Parametrised, byte-addressed instruction memory with a synchronous fetch request/response handshake and a working loader write port. It sits between the fetch stage and the program loader and replaces the combinational, unloadable instruction ROM. Bytes are stored big-endian: the byte at the lowest address is the instruction MSB. Fetch responses are registered, out-of-range accesses are flagged, and the response is held under back-pressure.

Parameters:
AWIDTH, 32, address width of load_addr and req_addr
IWIDTH, 32, instruction/load word width; must be 32
DEPTH_BYTES, 1024, storage size in bytes; power of two, at least 4
NOP_INST, 32'h00000013, value driven on rsp_inst after reset and on any errored fetch

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_en  input  1  write one word this cycle
load_addr  input  AWIDTH  byte address of the word to write
load_data  input  IWIDTH  word to write; bits [31:24] go to load_addr, [7:0] to load_addr+3
req_valid  input  1  fetch request valid
req_ready  output  1  fetch request accepted when high with req_valid
req_addr  input  AWIDTH  fetch byte address
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts the response
rsp_inst  output  IWIDTH  fetched instruction, big-endian assembled
rsp_err  output  1  fetch was out of range (or misaligned, see Optional Feature)

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_inst=NOP_INST, rsp_err=0. Memory contents are not reset.
- Storage: DEPTH_BYTES x 8-bit array.
- Load: if load_en and load_addr+3 <= DEPTH_BYTES-1, write 4 bytes on the rising edge. An out-of-range load is silently dropped. No partial writes.
- req_ready = !load_en && (!rsp_valid || rsp_ready). Loads take priority, so fetches stall during a load cycle.
- Accept: req_valid && req_ready on edge N gives rsp_valid=1 after edge N with the data. Latency is 1 cycle, with full throughput of one fetch per cycle while rsp_ready=1.
- Fetch data: {mem[a], mem[a+1], mem[a+2], mem[a+3]}. The read sees memory as of before edge N. A load in the same cycle is impossible because req_ready is low.
- Range: if a+3 > DEPTH_BYTES-1, including address-arithmetic wrap past 2^AWIDTH, then rsp_inst=NOP_INST and rsp_err=1. Overflow is computed at AWIDTH+1 bits.
- Hold: while rsp_valid && !rsp_ready, rsp_inst and rsp_err stay stable and no new request is accepted.
- Drain: if rsp_ready=1 and no new accept occurs, rsp_valid clears on the next edge. rsp_inst and rsp_err keep their last value.
- Reset mid-operation drops any pending response immediately.

Optional Feature:
Macro IMEM_MISALIGN_TRAP_EN.
- Defined: a fetch with req_addr[1:0] != 0 returns NOP_INST with rsp_err=1. Loads with load_addr[1:0] != 0 are dropped.
- Undefined: any byte alignment is legal. Data is assembled from 4 consecutive bytes; only the range check applies.

Test Plan:
- Reset then idle -> rsp_valid=0, rsp_inst=32'h00000013, rsp_err=0, req_ready=1.
- Load 32'hDEADBEEF @0x10, then fetch 0x10 -> one cycle later rsp_valid=1, rsp_inst=32'hDEADBEEF, rsp_err=0. Also fetch 0x11 with the macro undefined -> 32'hADBEEFxx, where xx is the byte at 0x14 (preload 0x14 with 32'h11223344, giving 32'hADBEEF11).
- Back-to-back fetches of 0x0, 0x4, 0x8 with rsp_ready=1 -> three consecutive valid responses, no bubbles. Then hold rsp_ready=0 for 3 cycles -> req_ready=0 and rsp_inst is stable until released.
- Fetch 0x3FC -> valid data, err=0. Fetch 0x3FD and 0xFFFFFFFE -> NOP_INST, err=1. Load to 0x3FE -> memory unchanged.
- Assert load_en while req_valid=1 -> req_ready=0 that cycle. The fetch is accepted the next cycle and returns the newly written word.
- Macro defined: fetch 0x12 -> NOP_INST, err=1. Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately, without waiting for a clock edge.
